uart_rx_baudsel: RTL and testbench

UART_RX_BAUDSEL -- requirements
Module: uart_rx_baudsel

---
 rtl/uart_rx_baudsel.sv | 219 +++++++++++++++++++++
 tb/tb_uart_rx_baudsel.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_baudsel.sv
// 8N1 UART receiver with a 2-bit baud selector, oversampled bit timing,
// frame-error detection, break handling and a sticky overrun flag.
module uart_rx_baudsel #(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       src_clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic [1:0] baud_sel,
    input  logic       rd_ack,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    function automatic int unsigned baud_rate(input int sel);
        case (sel)
            0:       return 9600;
            1:       return 57600;
            2:       return 115200;
            default: return 19200;
        endcase
    endfunction

    // Clocks per oversample tick, rounded to nearest, never zero.
    function automatic int unsigned calc_div(input int sel);
        int unsigned den;
        int unsigned div;
        den = baud_rate(sel) * OVERSAMPLE;
        div = (CLK_FREQ + den / 2) / den;
        return (div == 0) ? 1 : div;
    endfunction

    function automatic int unsigned max_div();
        int unsigned m;
        m = 1;
        for (int i = 0; i < 4; i++) begin
            if (calc_div(i) > m) m = calc_div(i);
        end
        return m;
    endfunction

    localparam int unsigned DIV_MAX     = max_div();
    localparam int          DIV_W       = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
    localparam int          TICK_W      = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam int          SYNC_STAGES = 2;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t                 state_reg;
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   rx_prev_reg;
    logic [1:0]             baud_reg;
    logic [DIV_W-1:0]       div_cnt_reg;
    logic [DIV_W-1:0]       div_cnt_next;
    logic [TICK_W-1:0]      tick_cnt_reg;
    logic [2:0]             bit_cnt_reg;
    logic [7:0]             shift_reg;
    logic [7:0]             rx_data_reg;
    logic                   rx_ready_reg;
    logic                   frame_err_reg;
    logic                   overrun_reg;
    logic                   busy_reg;

    logic                   rx_sync;
    logic                   start_edge;
    logic                   sample_tick;
    logic [DIV_W-1:0]       div_last [4];

    // Terminal divider count for each baud code, fixed at elaboration.
    for (genvar gi = 0; gi < 4; gi++) begin : g_div
        localparam int unsigned DIV_G = calc_div(gi);
        assign div_last[gi] = DIV_W'(DIV_G - 1);
    end

    assign rx_sync     = sync_reg[SYNC_STAGES-1];
    assign start_edge  = rx_prev_reg & ~rx_sync;
    assign sample_tick = (state_reg != ST_IDLE) && (div_cnt_reg == div_last[baud_reg]);

    // Held at zero in IDLE so the first tick lands one full DIV after the start edge.
    always_comb begin
        div_cnt_next = div_cnt_reg + DIV_W'(1);
        if ((state_reg == ST_IDLE) || sample_tick) begin
            div_cnt_next = '0;
        end
    end

    always_ff @(posedge src_clk) begin
        if (rst) begin
            sync_reg    <= '1;
            rx_prev_reg <= 1'b1;
        end else begin
            sync_reg    <= {sync_reg[SYNC_STAGES-2:0], rx_in};
            rx_prev_reg <= rx_sync;
        end
    end

    always_ff @(posedge src_clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            baud_reg      <= baud_sel;
            div_cnt_reg   <= '0;
            tick_cnt_reg  <= '0;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            rx_data_reg   <= '0;
            rx_ready_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            frame_err_reg <= 1'b0;
            div_cnt_reg   <= div_cnt_next;

            if (rd_ack && rx_ready_reg) begin
                rx_ready_reg <= 1'b0;
                overrun_reg  <= 1'b0;
            end

            unique case (state_reg)
                ST_IDLE: begin
                    baud_reg     <= baud_sel;
                    tick_cnt_reg <= '0;
                    bit_cnt_reg  <= '0;
                    if (start_edge) begin
                        state_reg <= ST_START;
                        busy_reg  <= 1'b1;
                    end
                end

                ST_START: begin
                    if (sample_tick) begin
                        if (tick_cnt_reg == TICK_MID) begin
                            tick_cnt_reg <= '0;
                            if (rx_sync) begin
                                state_reg <= ST_IDLE;
                                busy_reg  <= 1'b0;
                            end else begin
                                state_reg <= ST_DATA;
                            end
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + TICK_W'(1);
                        end
                    end
                end

                ST_DATA: begin
                    if (sample_tick) begin
                        if (tick_cnt_reg == TICK_LAST) begin
                            tick_cnt_reg <= '0;
                            shift_reg    <= {rx_sync, shift_reg[7:1]};
                            if (bit_cnt_reg == 3'd7) begin
                                state_reg <= ST_STOP;
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            end
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + TICK_W'(1);
                        end
                    end
                end

                ST_STOP: begin
                    if (sample_tick) begin
                        if (tick_cnt_reg == TICK_LAST) begin
                            tick_cnt_reg <= '0;
                            if (rx_sync) begin
                                // A new byte wins over a same-cycle acknowledge.
                                rx_data_reg  <= shift_reg;
                                rx_ready_reg <= 1'b1;
                                if (rx_ready_reg && !rd_ack) begin
                                    overrun_reg <= 1'b1;
                                end
                                state_reg <= ST_IDLE;
                                busy_reg  <= 1'b0;
                            end else begin
                                frame_err_reg <= 1'b1;
                                state_reg     <= ST_BREAK;
                            end
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + TICK_W'(1);
                        end
                    end
                end

                ST_BREAK: begin
                    if (rx_sync) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data   = rx_data_reg;
    assign rx_ready  = rx_ready_reg;
    assign frame_err = frame_err_reg;
    assign overrun   = overrun_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_uart_rx_baudsel.sv
// Bench for uart_rx_baudsel: drives serial frames at the selected rates and
// compares the outputs with a byte-level receive/acknowledge model.
`timescale 1ns/1ps
module tb_uart_rx_baudsel;

    localparam int unsigned CLK_FREQ   = 50000000;
    localparam int unsigned OVERSAMPLE = 16;

    logic       src_clk = 1'b0;
    logic       rst;
    logic       rx_in;
    logic [1:0] baud_sel;
    logic       rd_ack;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    always #5 src_clk = ~src_clk;

    uart_rx_baudsel #(
        .CLK_FREQ   (CLK_FREQ),
        .OVERSAMPLE (OVERSAMPLE)
    ) dut (
        .src_clk   (src_clk),
        .rst       (rst),
        .rx_in     (rx_in),
        .baud_sel  (baud_sel),
        .rd_ack    (rd_ack),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    int checks_cnt = 0;
    int errors_cnt = 0;

    task automatic check_value(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks_cnt++;
        if (actual !== expected) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Reference model: what the consumer should see, byte by byte.
    logic [7:0] exp_data;
    bit         exp_ready;
    bit         exp_overrun;

    function automatic int unsigned baud_of(input logic [1:0] s);
        case (s)
            2'b00:   return 9600;
            2'b01:   return 57600;
            2'b10:   return 115200;
            default: return 19200;
        endcase
    endfunction

    function automatic int div_of(input logic [1:0] s);
        real r;
        r = real'(CLK_FREQ) / (real'(baud_of(s)) * real'(OVERSAMPLE));
        return $rtoi(r + 0.5);
    endfunction

    function automatic int bit_clks(input logic [1:0] s);
        return div_of(s) * OVERSAMPLE;
    endfunction

    task automatic model_reset();
        exp_data    = 8'h00;
        exp_ready   = 1'b0;
        exp_overrun = 1'b0;
    endtask

    task automatic model_frame(input logic [7:0] d, input bit stop_ok);
        if (stop_ok) begin
            exp_overrun = exp_overrun | exp_ready;
            exp_ready   = 1'b1;
            exp_data    = d;
        end
    endtask

    task automatic model_ack();
        if (exp_ready) begin
            exp_ready   = 1'b0;
            exp_overrun = 1'b0;
        end
    endtask

    task automatic check_model(input string tag);
        check_value({tag, "_data"}, rx_data, exp_data);
        check_value({tag, "_ready"}, rx_ready, exp_ready);
        check_value({tag, "_overrun"}, overrun, exp_overrun);
    endtask

    // Per-frame observation, sampled on falling edges.
    int frame_cyc;
    int rise_cyc;
    int fe_cnt;
    bit busy_seen;
    bit ready_prev;

    task automatic begin_frame();
        frame_cyc  = 0;
        rise_cyc   = -1;
        fe_cnt     = 0;
        busy_seen  = 1'b0;
        ready_prev = rx_ready;
    endtask

    task automatic drive_bit(input logic v, input int clks);
        rx_in = v;
        repeat (clks) begin
            @(negedge src_clk);
            frame_cyc++;
            if (rx_ready && !ready_prev && rise_cyc < 0) rise_cyc = frame_cyc;
            ready_prev = rx_ready;
            if (frame_err) fe_cnt++;
            if (busy) busy_seen = 1'b1;
        end
    endtask

    // After the start bit is under way baud_sel is moved to new_sel (random if negative).
    task automatic send_frame(input logic [7:0] d, input logic [1:0] sel, input int new_sel, input int stop_low_bits);
        int bc;
        bc = bit_clks(sel);
        baud_sel = sel;
        drive_bit(1'b1, 4);
        begin_frame();
        drive_bit(1'b0, 10);
        baud_sel = (new_sel < 0) ? 2'($urandom) : 2'(new_sel);
        drive_bit(1'b0, bc - 10);
        for (int i = 0; i < 8; i++) drive_bit(d[i], bc);
        if (stop_low_bits > 0) drive_bit(1'b0, stop_low_bits * bc);
        else                   drive_bit(1'b1, bc / 2 + 16);
        model_frame(d, stop_low_bits == 0);
        $display("frame byte=%02h sel=%0d stop_low=%0d ready_at=%0d frame_err_pulses=%0d rx_data=%02h rx_ready=%0d overrun=%0d",
                 d, sel, stop_low_bits, rise_cyc, fe_cnt, rx_data, rx_ready, overrun);
    endtask

    // Stop-bit centre on the line is 9.5 bit periods after the start edge;
    // allow synchronizer and edge-detect delay plus two clocks of output latency.
    task automatic check_latency(input string tag, input logic [1:0] sel);
        int centre;
        centre = (9 * OVERSAMPLE + OVERSAMPLE / 2) * div_of(sel);
        check_value(tag, (rise_cyc >= centre && rise_cyc <= centre + 5), 1);
    endtask

    task automatic do_ack(input string tag);
        drive_bit(1'b1, $urandom_range(1, 20));
        rd_ack = 1'b1;
        @(negedge src_clk);
        rd_ack = 1'b0;
        model_ack();
        check_model(tag);
        $display("ack %s rx_ready=%0d overrun=%0d", tag, rx_ready, overrun);
    endtask

    initial begin
        logic [7:0] rnd_byte;
        int         bc;

        rst      = 1'b1;
        rx_in    = 1'b1;
        baud_sel = 2'b10;
        rd_ack   = 1'b0;
        model_reset();
        repeat (3) @(negedge src_clk);
        check_model("reset");
        check_value("reset_frame_err", frame_err, 0);
        check_value("reset_busy", busy, 0);
        rst = 1'b0;

        // 0xA5 at 115200
        send_frame(8'hA5, 2'b10, -1, 0);
        check_model("a5");
        check_value("a5_frame_err", fe_cnt, 0);
        check_value("a5_busy_seen", busy_seen, 1);
        check_latency("a5_latency", 2'b10);
        do_ack("a5_ack");

        // 0x3C at 57600 with baud_sel moved to 9600 mid-frame, then a 9600 frame
        send_frame(8'h3C, 2'b01, 0, 0);
        check_model("3c");
        check_latency("3c_latency", 2'b01);
        do_ack("3c_ack");
        rnd_byte = 8'($urandom);
        send_frame(rnd_byte, 2'b00, -1, 0);
        check_model("slow");
        check_latency("slow_latency", 2'b00);
        do_ack("slow_ack");

        // 100-clock glitch at 115200
        baud_sel = 2'b10;
        drive_bit(1'b1, 4);
        begin_frame();
        drive_bit(1'b0, 100);
        drive_bit(1'b1, 8 * div_of(2'b10) + 40);
        $display("glitch busy_seen=%0d busy=%0d frame_err_pulses=%0d", busy_seen, busy, fe_cnt);
        check_value("glitch_started", busy_seen, 1);
        check_value("glitch_idle", busy, 0);
        check_value("glitch_frame_err", fe_cnt, 0);
        check_model("glitch");
        rd_ack = 1'b1;
        @(negedge src_clk);
        rd_ack = 1'b0;
        model_ack();
        check_model("idle_ack");

        // 0x55 with stop held low for two bit periods, then 0x12
        send_frame(8'h55, 2'b10, -1, 2);
        check_value("break_frame_err", fe_cnt, 1);
        check_value("break_busy", busy, 1);
        check_model("break");
        drive_bit(1'b1, 20);
        check_value("break_exit", busy, 0);
        send_frame(8'h12, 2'b10, -1, 0);
        check_model("after_break");
        do_ack("after_break_ack");

        // Two bytes without acknowledge
        send_frame(8'h11, 2'b10, -1, 0);
        check_model("first");
        drive_bit(1'b1, $urandom_range(0, 50));
        send_frame(8'h22, 2'b10, -1, 0);
        check_model("overrun");
        do_ack("overrun_ack");

        // Reset pulse in the middle of data bit 3 of 0xFF
        bc = bit_clks(2'b10);
        baud_sel = 2'b10;
        drive_bit(1'b1, 4);
        begin_frame();
        drive_bit(1'b0, bc);
        drive_bit(1'b1, 3 * bc + $urandom_range(bc / 4, 3 * bc / 4));
        rst = 1'b1;
        @(negedge src_clk);
        rst = 1'b0;
        model_reset();
        check_model("mid_rst");
        check_value("mid_rst_busy", busy, 0);
        check_value("mid_rst_frame_err", frame_err, 0);
        drive_bit(1'b1, 6 * bc);
        check_model("post_rst");
        check_value("post_rst_busy", busy, 0);
        check_value("post_rst_frame_err", fe_cnt, 0);
        send_frame(8'h81, 2'b10, -1, 0);
        check_model("81");
        check_latency("81_latency", 2'b10);
        do_ack("81_ack");

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
